// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver state encoding and oversampling constants
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with configurable reset value
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_tick.sv
// rtl/uart_rx_tick.sv - 16x oversampling UART receiver driven by an external s_tick
// Optional even-parity stage and parity_err port enabled by UART_RX_PARITY_EN.
module uart_rx_tick
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic            parity_err
`endif
);

    // Stop phase may run past 16 ticks (1.5 or 2 stop bits), so s widens then.
    localparam int SW = (SB_TICK > OVERSAMPLE) ? 5 : 4;
    localparam int NW = $clog2(DBIT);

    state_t          state;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] b;
    logic            rx_s;
`ifdef UART_RX_PARITY_EN
    logic            par_bad;
`endif

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    assign dout = b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad      <= 1'b0;
            parity_err   <= 1'b0;
`endif
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == SW'(MID_TICK)) begin
                            // A start bit that is high again at mid-bit was a glitch.
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == SW'(OVERSAMPLE - 1)) begin
                            s <= '0;
                            b <= {rx_s, b[DBIT-1:1]};
                            if (n == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (s_tick) begin
                        if (s == SW'(OVERSAMPLE - 1)) begin
                            s       <= '0;
                            par_bad <= (^b) != rx_s;
                            state   <= STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (s_tick) begin
                        if (s == SW'(SB_TICK - 1)) begin
                            state        <= IDLE;
                            rx_done_tick <= 1'b1;
                            frame_err    <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                            parity_err   <= par_bad;
`endif
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_tick.sv
// tb/tb_uart_rx_tick.sv - scoreboard bench for uart_rx_tick with randomized frames
module tb_uart_rx_tick;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_tick #(.DBIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .rx           (rx),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    always #5 clk = ~clk;

    // One s_tick every 4 clk, changed on the falling edge.
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    int         exp_pulses = 0;
    logic [7:0] last_data = 8'h00;
    bit         prev_done = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pop the expected frame whenever the DUT reports completion.
    always @(negedge clk) begin
        if (reset_n && rx_done_tick) begin
            exp_t e;
            pulses++;
            if (prev_done) check("done_width", 2, 1);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("dout", dout, e.d);
                check("frame_err", frame_err, e.fe);
`ifdef UART_RX_PARITY_EN
                check("parity_err", parity_err, e.pe);
`endif
            end
        end
        prev_done = rx_done_tick;
    end

    task automatic drive_bit(input logic v, input int ticks);
        rx = v;
        repeat (ticks * 4) @(negedge clk);
    endtask

    // Line-level frame; expected result follows directly from the frame content.
    task automatic send_frame(input logic [7:0] data, input bit stop_ok,
                              input bit par_bit, input int gap_ticks);
        exp_t e;
        e.d  = data;
        e.fe = !stop_ok;
        e.pe = ($countones(data) % 2) != int'(par_bit);
        exp_q.push_back(e);
        exp_pulses++;
        last_data = data;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(data[i], 16);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_bit, 16);
`endif
        if (stop_ok) begin
            drive_bit(1'b1, 16);
        end else begin
            // Short low stop, then a full idle bit so the tail is seen as a glitch.
            drive_bit(1'b0, 10);
            drive_bit(1'b1, 16);
        end
        drive_bit(1'b1, gap_ticks);
    endtask

    task automatic wait_drain();
        int budget;
        budget = 2000;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    function automatic bit even_par(input logic [7:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    initial begin
        int p0;
        logic [7:0] rd;
        bit rs;

        #1;
        check("reset_done", rx_done_tick, 0);
        check("reset_dout", dout, 0);
        check("reset_frame_err", frame_err, 0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        drive_bit(1'b1, 8);

        send_frame(8'hA5, 1'b1, even_par(8'hA5), 4);
        wait_drain();
        send_frame(8'h3C, 1'b0, even_par(8'h3C), 4);
        wait_drain();

        p0 = pulses;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 40);
        check("glitch_no_pulse", pulses, p0);
        check("glitch_dout_kept", dout, last_data);

        send_frame(8'h00, 1'b1, even_par(8'h00), 0);
        send_frame(8'hFF, 1'b1, even_par(8'hFF), 4);
        wait_drain();

        // Abort a frame in the middle of data bit 3.
        p0 = pulses;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 16);
        drive_bit(1'b1, 8);
        reset_n = 1'b0;
        #1;
        check("midreset_done", rx_done_tick, 0);
        check("midreset_dout", dout, 0);
        check("midreset_frame_err", frame_err, 0);
`ifdef UART_RX_PARITY_EN
        check("midreset_parity_err", parity_err, 0);
`endif
        repeat (3) @(negedge clk);
        rx = 1'b1;
        reset_n = 1'b1;
        drive_bit(1'b1, 16);
        check("midreset_no_pulse", pulses, p0);
        send_frame(8'h55, 1'b1, even_par(8'h55), 4);
        wait_drain();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 4);
        send_frame(8'h07, 1'b1, 1'b1, 4);
        wait_drain();
`endif

        for (int k = 0; k < 16; k++) begin
            rd = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rd, rs, 1'($urandom_range(0, 1)), $urandom_range(0, 40));
        end
        wait_drain();
        drive_bit(1'b1, 20);
        check("pulse_count", pulses, exp_pulses);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_tick.md
UART_RX_TICK -- requirements
Module: uart_rx_tick

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, meaning data bits per frame (5..9).
REQ-002 The block SHALL have parameter SB_TICK, default 16, meaning oversample ticks in the stop bit (16, 24 or 32 for 1, 1.5 or 2 stop bits).
REQ-003 The block SHALL have port clk, input, 1, meaning the single system clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, meaning an asynchronous, active-low reset.
REQ-005 The block SHALL have port s_tick, input, 1, meaning a 16x-baud enable pulse, one clk wide, taken from the upstream mod-M counter's max_tick.
REQ-006 The block SHALL have port rx, input, 1, meaning the asynchronous serial line, idle high.
REQ-007 The block SHALL have port rx_done_tick, output, 1, meaning a one-clk pulse when a frame completes.
REQ-008 The block SHALL have port dout, output, DBIT, meaning the received data word, LSB first on the line.
REQ-009 The block SHALL have port frame_err, output, 1, meaning the stop bit was sampled low in the last frame.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer, reset value 1; all references to rx below mean the synchronized value (2 clk latency).
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP, plus PARITY when the parity macro is enabled.
REQ-012 The FSM SHALL use a 4-bit tick counter s (0..15) and a $clog2(DBIT)-bit bit counter n.
REQ-013 IDLE: rx==0 SHALL move the FSM to START and set s=0, independent of s_tick.
REQ-014 START, on s_tick with s==7: if rx==0, the FSM SHALL go to DATA with s=0 and n=0; if rx==1 (glitch), it SHALL return to IDLE with no pulse.
REQ-015 START/DATA/PARITY, on s_tick with s below its terminal value: s SHALL increment.
REQ-016 DATA, on s_tick with s==15: s SHALL reset to 0 and the shift register SHALL load {rx, b[DBIT-1:1]}; n==DBIT-1 SHALL leave DATA, otherwise n SHALL increment.
REQ-017 STOP, on s_tick with s==SB_TICK-1: the FSM SHALL go to IDLE, assert rx_done_tick for exactly one clk, and register frame_err = ~rx.
REQ-018 STOP: s SHALL be 5 bits wide when SB_TICK>16.
REQ-019 Without s_tick, every state SHALL hold.
REQ-020 dout SHALL equal the shift register, be stable from rx_done_tick until the next DATA shift, and have bit 0 as the first received bit.
REQ-021 frame_err and parity_err SHALL hold until the next rx_done_tick.
REQ-022 Back-to-back frames: IDLE SHALL accept a new start bit in the clk immediately after rx_done_tick.

Reset
REQ-023 reset_n low SHALL asynchronously force state=IDLE, s=0, n=0, b=0, rx_done_tick=0, dout=0, frame_err=0, parity_err=0 and synchronizer flops=1.
REQ-024 Reset mid-frame SHALL abandon the frame with no rx_done_tick; reception SHALL resume from IDLE after release.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: after DATA the FSM SHALL enter PARITY, sample rx at s==15, assert parity_err = (XOR of data bits) != rx (even parity), and expose output parity_err [1] updated with rx_done_tick.
REQ-026 Macro UART_RX_PARITY_EN undefined: the PARITY state, its logic and the parity_err port SHALL be absent; DATA SHALL go directly to STOP.

Structure
REQ-027 A shared package uart_pkg SHALL hold the state typedef (enum logic [2:0]: IDLE, START, DATA, PARITY, STOP) and constants OVERSAMPLE=16 and MID_TICK=7.
REQ-028 The synchronizer SHALL be a sub-module sync_2ff with ports clk, reset_n, d and q, reset value parameterized, set to 1 here.
REQ-029 The mod-M tick generator SHALL remain external and not be instantiated inside this block.

Verification
REQ-030 Verification SHALL use the setup DBIT=8, SB_TICK=16, s_tick every 4 clk.
REQ-031 Scenario: frame 0xA5, stop=1 -> dout=0xA5, one rx_done_tick, frame_err=0.
REQ-032 Scenario: frame 0x3C with the stop bit driven 0 -> dout=0x3C, rx_done_tick, frame_err=1.
REQ-033 Scenario: rx low for 4 s_ticks then high -> FSM back to IDLE, no rx_done_tick, dout unchanged.
REQ-034 Scenario: frames 0x00 then 0xFF with zero idle gap -> two rx_done_tick pulses, dout 0x00 then 0xFF.
REQ-035 Scenario: reset_n pulsed low during DATA bit 3 -> all outputs 0 immediately, no pulse; a following 0x55 frame is received correctly.
REQ-036 Scenario (UART_RX_PARITY_EN): 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
